// File: rtl/inst_fetch_decode.sv
// Sequential instruction fetch/decode: fetches one word per instruction from a
// combinational-read memory and presents its fields to the ALU stage under a
// valid/ready handshake. Define IFD_SKIP_NOP_EN to drop opcode 3'b111 as a NOP.
module inst_fetch_decode #(
  parameter int IADDR_W = 4,
  parameter int INST_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [IADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0]  inst_data,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [2:0]         opcode,
  output logic [1:0]         op_addr_1,
  output logic [1:0]         op_addr_2,
  output logic               busy,
  output logic               done,
  output logic [IADDR_W:0]   issued_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [IADDR_W-1:0] PC_ONE  = 1;
  localparam logic [IADDR_W:0]   CNT_ONE = 1;

  state_t             r_state;
  state_t             w_next;
  logic [IADDR_W-1:0] r_pc;
  logic [INST_W-1:0]  r_ir;
  logic [IADDR_W:0]   r_cnt;

  logic w_nop;
  logic w_adv;
  logic w_xfer;
  logic w_end;
  logic w_start_run;

`ifdef IFD_SKIP_NOP_EN
  assign w_nop = (r_ir[7:5] == 3'b111);
`else
  assign w_nop = 1'b0;
`endif

  // A skipped NOP advances the program exactly as a transfer would, minus the count.
  assign w_adv       = (r_state == S_ISSUE) && (w_nop || issue_ready);
  assign w_xfer      = (r_state == S_ISSUE) && !w_nop && issue_ready;
  assign w_end       = r_ir[0] || (r_pc == '1);
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_ISSUE;
      S_ISSUE: if (w_adv) w_next = w_end ? S_DONE : S_FETCH;
      S_DONE:  if (start) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    issue_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_FETCH: busy = 1'b1;
      S_ISSUE: begin
        busy        = 1'b1;
        issue_valid = !w_nop;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_start_run) begin
        r_pc  <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_FETCH) begin
        r_ir <= inst_data;
      end
      if (w_xfer) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_adv && !w_end) begin
        r_pc <= r_pc + PC_ONE;
      end
    end
  end

  assign inst_addr  = r_pc;
  assign issued_cnt = r_cnt;
  assign opcode     = r_ir[7:5];
  assign op_addr_1  = r_ir[4:3];
  assign op_addr_2  = r_ir[2:1];

endmodule
